// File: rtl/fhn_stim_sequencer.sv
// Phase-table stimulus sequencer for the FHN neuron core: resets the core, steps through
// programmed (amplitude, duration) phases and counts v-spikes per phase with hysteresis.
module fhn_stim_sequencer #(
    parameter int DATA_W     = 16,
    parameter int FRC_BITS   = 12,
    parameter int N_PHASES   = 8,
    parameter int DUR_W      = 16,
    parameter int CNT_W      = 12,
    parameter int SETTLE_CYC = 10,
    parameter logic signed [DATA_W-1:0] V_HI = $signed(DATA_W'(1) << FRC_BITS),
    parameter logic signed [DATA_W-1:0] V_LO = $signed(DATA_W'(0))
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(N_PHASES)-1:0]   cfg_addr,
    input  logic signed [DATA_W-1:0]      cfg_amp,
    input  logic [DUR_W-1:0]              cfg_dur,
    input  logic                          cfg_last,
    input  logic                          start,
    input  logic                          abort,
    input  logic signed [DATA_W-1:0]      v_in,
    output logic signed [DATA_W-1:0]      i_stim,
    output logic                          core_rst,
    output logic                          busy,
    output logic [$clog2(N_PHASES)-1:0]   phase_idx,
    output logic                          done,
    output logic                          spike,
    input  logic [$clog2(N_PHASES)-1:0]   rd_addr,
    output logic [CNT_W-1:0]              rd_count
);
    localparam int AW = $clog2(N_PHASES);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, FIN} state_t;

    state_t                     state_r;
    logic signed [DATA_W-1:0]   amp_r   [N_PHASES];
    logic [DUR_W-1:0]           dur_r   [N_PHASES];
    logic [N_PHASES-1:0]        last_r;
    logic [CNT_W-1:0]           count_r [N_PHASES];
    logic [SW-1:0]              settle_cnt_r;
    logic [DUR_W-1:0]           dur_cnt_r;
    logic                       armed_r;
    logic [AW-1:0]              nxt_idx_s;

    // A programmed duration of zero still occupies one cycle.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign nxt_idx_s = phase_idx + AW'(1);

    // Sequencer FSM, phase table, spike detector and per-phase counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            i_stim       <= '0;
            core_rst     <= 1'b0;
            busy         <= 1'b0;
            phase_idx    <= '0;
            done         <= 1'b0;
            spike        <= 1'b0;
            armed_r      <= 1'b1;
            settle_cnt_r <= '0;
            dur_cnt_r    <= '0;
            last_r       <= '0;
            for (int i = 0; i < N_PHASES; i++) begin
                amp_r[i]   <= '0;
                dur_r[i]   <= '0;
                count_r[i] <= '0;
            end
        end else begin
            done  <= 1'b0;
            spike <= 1'b0;
            if (cfg_we && !busy) begin
                amp_r[cfg_addr]  <= cfg_amp;
                dur_r[cfg_addr]  <= cfg_dur;
                last_r[cfg_addr] <= cfg_last;
            end
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        state_r      <= SETTLE;
                        core_rst     <= 1'b1;
                        i_stim       <= '0;
                        busy         <= 1'b1;
                        phase_idx    <= '0;
                        settle_cnt_r <= SW'(SETTLE_CYC);
                        for (int i = 0; i < N_PHASES; i++) count_r[i] <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_r  <= IDLE;
                        i_stim   <= '0;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                    end else if (settle_cnt_r == SW'(1)) begin
                        state_r   <= RUN;
                        phase_idx <= '0;
                        i_stim    <= amp_r[0];
                        dur_cnt_r <= eff_dur(dur_r[0]);
                        core_rst  <= 1'b0;
                        armed_r   <= 1'b1;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - SW'(1);
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_r  <= IDLE;
                        i_stim   <= '0;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        // Spike credit uses the current index, so last-cycle spikes stay in-phase.
                        if (armed_r && (v_in >= V_HI)) begin
                            spike   <= 1'b1;
                            armed_r <= 1'b0;
                            if (count_r[phase_idx] != '1)
                                count_r[phase_idx] <= count_r[phase_idx] + CNT_W'(1);
                        end else if (!armed_r && (v_in <= V_LO)) begin
                            armed_r <= 1'b1;
                        end
                        if (dur_cnt_r == DUR_W'(1)) begin
                            if (last_r[phase_idx] || (phase_idx == AW'(N_PHASES - 1))) begin
                                state_r <= FIN;
                                i_stim  <= '0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                phase_idx <= nxt_idx_s;
                                i_stim    <= amp_r[nxt_idx_s];
                                dur_cnt_r <= eff_dur(dur_r[nxt_idx_s]);
                            end
                        end else begin
                            dur_cnt_r <= dur_cnt_r - DUR_W'(1);
                        end
                    end
                end
                FIN: begin
                    state_r  <= IDLE;
                    i_stim   <= '0;
                    core_rst <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    i_stim   <= '0;
                    core_rst <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Registered count readback; shows live counts while a run is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else begin
            rd_count <= count_r[rd_addr];
        end
    end
endmodule

// File: tb/tb_fhn_stim_sequencer.sv
// Directed self-checking bench for fhn_stim_sequencer (second instance uses a 4-bit counter).
module tb_fhn_stim_sequencer;
    logic               clk, rst, cfg_we, cfg_last, start, abort;
    logic [2:0]         cfg_addr, rd_addr, phase_idx, phase_idx_b;
    logic signed [15:0] cfg_amp, v_in, i_stim, i_stim_b;
    logic [15:0]        cfg_dur;
    logic               core_rst, busy, done, spike, core_rst_b, busy_b, done_b, spike_b;
    logic [11:0]        rd_count;
    logic [3:0]         rd_count_b;
    int n_vec = 0;
    int n_err = 0;

    fhn_stim_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_amp(cfg_amp),
        .cfg_dur(cfg_dur), .cfg_last(cfg_last), .start(start), .abort(abort), .v_in(v_in),
        .i_stim(i_stim), .core_rst(core_rst), .busy(busy), .phase_idx(phase_idx), .done(done),
        .spike(spike), .rd_addr(rd_addr), .rd_count(rd_count));

    fhn_stim_sequencer #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_amp(cfg_amp),
        .cfg_dur(cfg_dur), .cfg_last(cfg_last), .start(start), .abort(abort), .v_in(v_in),
        .i_stim(i_stim_b), .core_rst(core_rst_b), .busy(busy_b), .phase_idx(phase_idx_b),
        .done(done_b), .spike(spike_b), .rd_addr(rd_addr), .rd_count(rd_count_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic prog(input logic [2:0] a, input logic signed [15:0] amp,
                        input logic [15:0] dur, input logic last);
        cfg_we = 1'b1; cfg_addr = a; cfg_amp = amp; cfg_dur = dur; cfg_last = last;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic wait_settle(output int n);
        n = 0;
        while (core_rst === 1'b1 && n < 100) begin n++; cyc(1); end
    endtask

    task automatic measure(input logic signed [15:0] level, output int n);
        n = 0;
        while (i_stim === level && busy === 1'b1 && n < 40000) begin n++; cyc(1); end
    endtask

    task automatic test_reset();
        int n;
        n_vec++; if (i_stim !== 16'sd0 || busy !== 1'b0 || core_rst !== 1'b0 || done !== 1'b0 || spike !== 1'b0 || phase_idx !== 3'd0 || rd_count !== 12'd0) begin
            $display("FAIL reset_state: i_stim=%0d busy=%b core_rst=%b done=%b spike=%b idx=%0d cnt=%0d, want all 0", i_stim, busy, core_rst, done, spike, phase_idx, rd_count); n_err++; end
        rst = 1'b0; cyc(1);
        prog(3'd0, 16'sd1024, 16'd5, 1'b0);
        prog(3'd1, 16'sd2048, 16'd30, 1'b1);
        kick(); wait_settle(n); cyc(15);
        n_vec++; if (i_stim !== 16'sd2048 || phase_idx !== 3'd1) begin
            $display("FAIL midrun_pre: i_stim=%0d idx=%0d, want 2048/1", i_stim, phase_idx); n_err++; end
        #2 rst = 1'b1; #1;
        n_vec++; if (i_stim !== 16'sd0 || busy !== 1'b0 || core_rst !== 1'b0) begin
            $display("FAIL async_reset: i_stim=%0d busy=%b core_rst=%b, want 0/0/0", i_stim, busy, core_rst); n_err++; end
        cyc(2); rst = 1'b0; cyc(1);
        // Cleared table: dur=0 and no last bit, so eight 1-cycle phases.
        kick(); wait_settle(n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin n++; cyc(1); end
        n_vec++; if (n !== 8 || done !== 1'b1 || phase_idx !== 3'd7) begin
            $display("FAIL cleared_table: busy_cycles=%0d done=%b idx=%0d, want 8/1/7", n, done, phase_idx); n_err++; end
    endtask

    task automatic test_sequence();
        int n;
        prog(3'd0, 16'sd2048, 16'd4000, 1'b0);
        prog(3'd1, 16'sd0, 16'd20000, 1'b0);
        prog(3'd2, 16'sd4096, 16'd10000, 1'b1);
        kick(); wait_settle(n);
        n_vec++; if (n !== 10) begin $display("FAIL settle_len: got %0d want 10", n); n_err++; end
        n_vec++; if (phase_idx !== 3'd0 || busy !== 1'b1) begin
            $display("FAIL run_entry: idx=%0d busy=%b, want 0/1", phase_idx, busy); n_err++; end
        measure(16'sd2048, n);
        n_vec++; if (n !== 4000) begin $display("FAIL phase0_len: got %0d want 4000", n); n_err++; end
        measure(16'sd0, n);
        n_vec++; if (n !== 20000 || phase_idx !== 3'd2) begin $display("FAIL phase1_len: got %0d idx %0d want 20000/2", n, phase_idx); n_err++; end
        measure(16'sd4096, n);
        n_vec++; if (n !== 10000) begin $display("FAIL phase2_len: got %0d want 10000", n); n_err++; end
        n_vec++; if (done !== 1'b1 || busy !== 1'b0 || i_stim !== 16'sd0) begin
            $display("FAIL fin: done=%b busy=%b i_stim=%0d, want 1/0/0", done, busy, i_stim); n_err++; end
        cyc(1);
        n_vec++; if (done !== 1'b0 || phase_idx !== 3'd2) begin $display("FAIL done_pulse: done=%b idx=%0d want 0/2", done, phase_idx); n_err++; end
    endtask

    task automatic test_spikes();
        int n, sp;
        prog(3'd0, 16'sd100, 16'd1000, 1'b1);
        kick(); wait_settle(n);
        sp = 0;
        for (int t = 0; t < 1000; t++) begin
            v_in = 16'(-8192 + ((t % 100) * 16384) / 99);
            cyc(1);
            if (spike === 1'b1) sp++;
        end
        v_in = 16'sd0; rd_addr = 3'd0; cyc(1);
        n_vec++; if (sp !== 10) begin $display("FAIL sawtooth_pulses: got %0d want 10", sp); n_err++; end
        n_vec++; if (rd_count !== 12'd10) begin $display("FAIL sawtooth_count: got %0d want 10", rd_count); n_err++; end
    endtask

    task automatic test_hysteresis();
        int n, sp;
        prog(3'd0, 16'sd0, 16'd300, 1'b1);
        kick(); wait_settle(n);
        sp = 0;
        for (int t = 0; t < 300; t++) begin
            v_in = (t == 0) ? 16'sd8192 : ((t % 2) ? 16'sd4100 : 16'sd4000);
            cyc(1);
            if (spike === 1'b1) sp++;
        end
        v_in = 16'sd0; rd_addr = 3'd0; cyc(1);
        n_vec++; if (sp !== 1 || rd_count !== 12'd1) begin
            $display("FAIL hysteresis: pulses=%0d count=%0d want 1/1", sp, rd_count); n_err++; end
    endtask

    task automatic test_saturate();
        int n;
        prog(3'd0, 16'sd0, 16'd2100, 1'b1);
        kick(); wait_settle(n);
        for (int t = 0; t < 2000; t++) begin
            v_in = 16'(-8192 + ((t % 100) * 16384) / 99);
            cyc(1);
        end
        v_in = 16'sd0; n = 0;
        while (busy === 1'b1 && n < 200) begin n++; cyc(1); end
        rd_addr = 3'd0; cyc(1);
        n_vec++; if (rd_count !== 12'd20) begin $display("FAIL count20: got %0d want 20", rd_count); n_err++; end
        n_vec++; if (rd_count_b !== 4'd15) begin $display("FAIL saturate: got %0d want 15", rd_count_b); n_err++; end
    endtask

    task automatic test_abort();
        int n;
        prog(3'd0, 16'sd1024, 16'd100, 1'b0);
        prog(3'd1, 16'sd2048, 16'd200, 1'b1);
        kick(); wait_settle(n);
        measure(16'sd1024, n);
        n_vec++; if (n !== 100 || phase_idx !== 3'd1) begin $display("FAIL abort_p0: len=%0d idx=%0d want 100/1", n, phase_idx); n_err++; end
        cyc(20);
        prog(3'd1, -16'sd1000, 16'd5, 1'b1);
        cyc(29);
        abort = 1'b1; cyc(1);
        n_vec++; if (i_stim !== 16'sd0 || busy !== 1'b0 || core_rst !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort: i_stim=%0d busy=%b core_rst=%b done=%b want 0/0/0/0", i_stim, busy, core_rst, done); n_err++; end
        start = 1'b1; cyc(3);
        n_vec++; if (busy !== 1'b0 || core_rst !== 1'b0) begin
            $display("FAIL start_under_abort: busy=%b core_rst=%b want 0/0", busy, core_rst); n_err++; end
        start = 1'b0; abort = 1'b0; cyc(1);
        kick(); wait_settle(n);
        measure(16'sd1024, n);
        measure(16'sd2048, n);
        n_vec++; if (n !== 200 || done !== 1'b1) begin
            $display("FAIL cfg_we_busy: phase1_len=%0d done=%b want 200/1", n, done); n_err++; end
    endtask

    task automatic test_dur_zero();
        int n;
        prog(3'd0, 16'sd512, 16'd50, 1'b0);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_amp = 16'sd777; cfg_dur = 16'd0; cfg_last = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0; cfg_we = 1'b0;
        wait_settle(n);
        n_vec++; if (i_stim !== 16'sd777) begin $display("FAIL we_with_start: i_stim=%0d want 777", i_stim); n_err++; end
        cyc(1);
        n_vec++; if (i_stim !== 16'sd0 || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL dur_zero: i_stim=%0d done=%b busy=%b want 0/1/0", i_stim, done, busy); n_err++; end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_amp = 16'sd0; cfg_dur = 16'd0;
        cfg_last = 1'b0; start = 1'b0; abort = 1'b0; v_in = 16'sd0; rd_addr = 3'd0;
        cyc(2);
        test_reset();
        cyc(2); test_sequence();
        cyc(2); test_spikes();
        cyc(2); test_hysteresis();
        cyc(2); test_saturate();
        cyc(2); test_abort();
        cyc(2); test_dur_zero();
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fhn_stim_sequencer.md
Name: fhn_stim_sequencer

Overview:
- Programmable stimulus controller for the FHN neuron core.
- Holds a table of up to N_PHASES stimulus phases (amplitude, duration) and drives the core's 16-bit Q4.12 current input phase by phase.
- Resets the core before each run and counts spikes on the core's v output per phase, so runs are repeatable without a hand-written bench sequence.

Parameters:
DATA_W, 16, width of stimulus and membrane signals (signed Q4.12)
FRC_BITS, 12, fractional bits of DATA_W values
N_PHASES, 8, phase table depth (power of two)
DUR_W, 16, phase duration counter width (cycles)
CNT_W, 12, per-phase spike counter width
SETTLE_CYC, 10, cycles core_rst is held at start of a run (>=1)
V_HI, 4096, spike detect threshold (1.0 in Q4.12), signed
V_LO, 0, re-arm threshold (0.0), signed; V_LO < V_HI

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  write phase table entry (ignored while busy)
cfg_addr  in  log2(N_PHASES)  entry index
cfg_amp  in  DATA_W  signed stimulus amplitude
cfg_dur  in  DUR_W  phase length in cycles (0 treated as 1)
cfg_last  in  1  entry is final phase of the run
start  in  1  begin run (ignored while busy)
abort  in  1  terminate run immediately
v_in  in  DATA_W  signed membrane value from core
i_stim  out  DATA_W  signed stimulus to core, registered
core_rst  out  1  reset to core, registered
busy  out  1  high in SETTLE and RUN
phase_idx  out  log2(N_PHASES)  current phase index
done  out  1  one-cycle pulse at normal run completion
spike  out  1  one-cycle pulse per detected spike
rd_addr  in  log2(N_PHASES)  spike count read index
rd_count  out  CNT_W  spike count of phase rd_addr, 1-cycle latency

Behaviour:
- Reset (async, rst=1): state IDLE; i_stim=0; core_rst=0; busy=0; phase_idx=0; done=0; spike=0; rd_count=0. Table cleared: amp=0, dur=0, last=0. All counts=0. armed=1.
- FSM states: IDLE, SETTLE, RUN, FIN.
- IDLE:
  - start=1 with abort=0 -> SETTLE next cycle.
  - On that edge: all counts cleared, core_rst=1, i_stim=0, busy=1, settle counter loaded with SETTLE_CYC.
- SETTLE:
  - core_rst stays high for exactly SETTLE_CYC cycles, then -> RUN with phase_idx=0.
  - On the same edge: i_stim=amp[0], duration counter loaded with max(dur[0],1), core_rst=0, armed=1.
- RUN:
  - i_stim holds amp[phase_idx] for exactly max(dur,1) cycles.
  - At phase end, if last[phase_idx]=1 or phase_idx=N_PHASES-1 -> FIN. Otherwise phase_idx increments and i_stim takes the next amp on the same edge, with no gap cycle.
- FIN: i_stim=0, busy=0, done=1 for one cycle -> IDLE. phase_idx holds its final value until the next start.
- abort=1 in SETTLE/RUN/FIN: -> IDLE next edge with i_stim=0, core_rst=0, busy=0, no done pulse; counts retained. abort has priority over start and over phase advance.
- Spike detect (RUN only):
  - When armed=1 and v_in >= V_HI: spike=1 next cycle, count[phase_idx]++ (saturating at 2^CNT_W-1), armed=0.
  - When armed=0 and v_in <= V_LO: armed=1.
  - A spike at the last cycle of a phase is credited to that phase.
- Comparisons are signed full-width. No arithmetic on amp; passed through unchanged.
- cfg_we while busy is dropped (table unchanged). cfg_we and start in the same IDLE cycle: write is committed and the run uses the new value.
- rd_count is registered: reflects count[rd_addr] one cycle after rd_addr is presented. It is valid during a run, showing the live count.

Test Plan:
- Reset mid-RUN (phase 1, i_stim=2048): rst=1 -> i_stim=0, busy=0, core_rst=0 asynchronously; table reads back dur=0.
- Program entry0={2048,4000,0}, entry1={0,20000,0}, entry2={4096,10000,1}; start -> core_rst high 10 cycles, then i_stim=2048 for exactly 4000 cycles, 0 for 20000, 4096 for 10000, then done pulse once, i_stim=0.
- Drive v_in as a sawtooth -8192->8192 with period 100 during a single 1000-cycle phase -> exactly 10 spike pulses, rd_count(0)=10. Dithering v_in between 4000 and 4100 after a spike -> no extra counts (hysteresis).
- CNT_W=4, 20 spikes in one phase -> count saturates at 15.
- abort asserted 50 cycles into phase 1 -> i_stim=0 next edge, no done pulse. A subsequent start with abort held high is ignored. cfg_we during RUN does not alter the table.
- Entry with dur=0 and last=1 -> phase lasts 1 cycle. A table with no last bit set runs all 8 phases and then finishes.
